// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } sa_state_t;

  // Bit-counter width; a one-bit operand still needs a one-bit counter.
  function automatic int calc_cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; the only arithmetic element of the serial sequencer.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full adder, one bit per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int               CNT_W    = calc_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sa_state_t        r_state;
  sa_state_t        w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic [WIDTH-1:0] w_s_sh_next;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             w_fa_s;
  logic             w_fa_cout;
  logic             w_last;

  full_adder fa (
    .a   (r_a_sh[0]),
    .b   (r_b_sh[0]),
    .cin (r_carry),
    .s   (w_fa_s),
    .cout(w_fa_cout)
  );

  assign w_last      = (r_cnt == LAST_CNT);
  assign w_s_sh_next = (r_s_sh >> 1) | (WIDTH'(w_fa_s) << (WIDTH - 1));

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)                w_next_state = ST_RUN;
      ST_RUN:  if (abort)                   w_next_state = ST_IDLE;
               else if (w_last)             w_next_state = ST_DONE;
      ST_DONE: if (abort || out_ready)      w_next_state = ST_IDLE;
      default:                              w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_RUN:  busy     = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: every datapath register is reset, including the shift registers,
  // so nothing undefined can ever reach s/cout/ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_s_sh  <= '0;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_s_sh  <= w_s_sh_next;
          r_carry <= w_fa_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          // On the MSB step r_carry is the carry into the MSB, so the result
          // registers are loaded here and hold untouched until the next result.
          if (w_last && !abort) begin
            r_s    <= w_s_sh_next;
            r_cout <= w_fa_cout;
            r_ovf  <= r_carry ^ w_fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH = 8, 32 and 1.
module tb_serial_add_ctrl;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid_v [3];
  logic        out_ready_v[3];
  logic        abort_v    [3];
  logic        cin_v      [3];
  logic [31:0] a_v        [3];
  logic [31:0] b_v        [3];

  logic [7:0]  s8;
  logic [31:0] s32;
  logic        s1;
  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic        co0, co1, co2, of0, of1, of2, bz0, bz1, bz2;

  logic [31:0] s_o [3];
  logic        ir_o[3];
  logic        ov_o[3];
  logic        co_o[3];
  logic        of_o[3];
  logic        bz_o[3];

  assign s_o[0] = {24'd0, s8};
  assign s_o[1] = s32;
  assign s_o[2] = {31'd0, s1};
  assign ir_o[0] = ir0; assign ir_o[1] = ir1; assign ir_o[2] = ir2;
  assign ov_o[0] = ov0; assign ov_o[1] = ov1; assign ov_o[2] = ov2;
  assign co_o[0] = co0; assign co_o[1] = co1; assign co_o[2] = co2;
  assign of_o[0] = of0; assign of_o[1] = of1; assign of_o[2] = of2;
  assign bz_o[0] = bz0; assign bz_o[1] = bz1; assign bz_o[2] = bz2;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(ir0),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .cin(cin_v[0]), .abort(abort_v[0]),
    .out_valid(ov0), .out_ready(out_ready_v[0]), .s(s8), .cout(co0),
    .ovf(of0), .busy(bz0)
  );

  serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(ir1),
    .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .abort(abort_v[1]),
    .out_valid(ov1), .out_ready(out_ready_v[1]), .s(s32), .cout(co1),
    .ovf(of1), .busy(bz1)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(ir2),
    .a(a_v[2][0:0]), .b(b_v[2][0:0]), .cin(cin_v[2]), .abort(abort_v[2]),
    .out_valid(ov2), .out_ready(out_ready_v[2]), .s(s1), .cout(co2),
    .ovf(of2), .busy(bz2)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int wid(input int k);
    return (k == 0) ? 8 : (k == 1) ? 32 : 1;
  endfunction

  // Reference: plain integer addition, overflow from operand/result sign bits.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic c);
    logic [32:0] full;
    logic [31:0] m;
    exp_t        e;
    m      = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    full   = {1'b0, a & m} + {1'b0, b & m} + {32'd0, c};
    e.s    = full[31:0] & m;
    e.cout = full[w];
    e.ovf  = (a[w-1] == b[w-1]) && (e.s[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic push_exp(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic drop_last(input int k);
    case (k)
      0:       if (q0.size() > 0) void'(q0.pop_back());
      1:       if (q1.size() > 0) void'(q1.pop_back());
      default: if (q2.size() > 0) void'(q2.pop_back());
    endcase
  endtask

  // Result consumer side of the scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n && ov_o[k] && out_ready_v[k] && !abort_v[k]) begin
        exp_t e;
        bit   have;
        have = 1'b0;
        case (k)
          0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) check("unexpected_result", 64'd1, 64'd0);
        else begin
          check("sum",  {32'd0, s_o[k]}, {32'd0, e.s});
          check("cout", {63'd0, co_o[k]}, {63'd0, e.cout});
          check("ovf",  {63'd0, of_o[k]}, {63'd0, e.ovf});
        end
      end
    end
  end

  // Drives one operand pair; returns the number of cycles spent waiting for in_ready.
  task automatic send(input int k, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input bit bp, output int n_wait);
    bit ok;
    ok     = 1'b1;
    n_wait = 0;
    @(posedge clk); #1;
    in_valid_v[k] = 1'b1;
    a_v[k]        = a;
    b_v[k]        = b;
    cin_v[k]      = c;
    forever begin
      @(negedge clk);
      if (ir_o[k]) break;
      n_wait++;
      if (n_wait > 500) begin
        check("accept_timeout", 64'd0, 64'd1);
        ok = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (bp) out_ready_v[k] = 1'($urandom_range(0, 1));
    end
    if (ok) push_exp(k, model(wid(k), a, b, c));
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
    if (bp) out_ready_v[k] = 1'($urandom_range(0, 1));
  endtask

  // Counts edges from the caller's point until out_valid is seen.
  task automatic wait_valid(input int k, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (ov_o[k]) break;
      if (lat > 500) begin
        check("valid_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic check_idle_reset(input int k);
    check("rst_in_ready",  {63'd0, ir_o[k]}, 64'd1);
    check("rst_out_valid", {63'd0, ov_o[k]}, 64'd0);
    check("rst_busy",      {63'd0, bz_o[k]}, 64'd0);
    check("rst_s",         {32'd0, s_o[k]},  64'd0);
    check("rst_cout",      {63'd0, co_o[k]}, 64'd0);
    check("rst_ovf",       {63'd0, of_o[k]}, 64'd0);
  endtask

  initial begin
    int nw, lat, seen;
    logic [31:0] held_s;
    for (int k = 0; k < 3; k++) begin
      in_valid_v[k]  = 1'b0;
      out_ready_v[k] = 1'b1;
      abort_v[k]     = 1'b0;
      cin_v[k]       = 1'b0;
      a_v[k]         = '0;
      b_v[k]         = '0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check_idle_reset(k);
    #9 rst_n = 1'b1;

    // Basic add, latency and back-to-back issue interval.
    send(0, 32'h3C, 32'h05, 1'b0, 1'b0, nw);
    wait_valid(0, lat);
    check("latency_w8", 64'(lat), 64'd8);
    send(0, 32'hFF, 32'h00, 1'b1, 1'b0, nw);
    check("issue_gap_w8", 64'(nw + 2), 64'd2);
    wait_valid(0, lat);
    send(0, 32'h7F, 32'h01, 1'b0, 1'b0, nw);
    wait_valid(0, lat);

    // Unbounded backpressure on the 32-bit instance.
    out_ready_v[1] = 1'b0;
    send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, nw);
    wait_valid(1, lat);
    check("latency_w32", 64'(lat), 64'd32);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid",    {63'd0, ov_o[1]}, 64'd1);
      check("bp_in_ready", {63'd0, ir_o[1]}, 64'd0);
      check("bp_s",        {32'd0, s_o[1]},  64'hFFFF_FFFF);
      check("bp_cout",     {63'd0, co_o[1]}, 64'd1);
    end
    @(posedge clk); #1 out_ready_v[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_released", {63'd0, ov_o[1]}, 64'd0);

    // Abort three cycles into RUN discards the operation.
    held_s = s_o[0];
    send(0, 32'h55, 32'h11, 1'b0, 1'b0, nw);
    repeat (2) @(posedge clk);
    #1 abort_v[0] = 1'b1;
    drop_last(0);
    @(posedge clk); #1 abort_v[0] = 1'b0;
    @(negedge clk);
    check("abort_out_valid", {63'd0, ov_o[0]}, 64'd0);
    check("abort_in_ready",  {63'd0, ir_o[0]}, 64'd1);
    check("abort_s_held",    {32'd0, s_o[0]},  {32'd0, held_s});
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov_o[0]) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    send(0, 32'h10, 32'h20, 1'b0, 1'b0, nw);
    wait_valid(0, lat);

    // Abort in IDLE does not block a simultaneous handshake.
    @(posedge clk); #1 abort_v[0] = 1'b1;
    send(0, 32'h81, 32'h81, 1'b0, 1'b0, nw);
    abort_v[0] = 1'b0;
    wait_valid(0, lat);
    check("idle_abort_latency", 64'(lat), 64'd8);

    // Abort wins over out_ready in DONE.
    @(posedge clk); #1 out_ready_v[0] = 1'b0;
    send(0, 32'h22, 32'h33, 1'b1, 1'b0, nw);
    wait_valid(0, lat);
    @(posedge clk); #1;
    abort_v[0]     = 1'b1;
    out_ready_v[0] = 1'b1;
    drop_last(0);
    @(posedge clk); #1 abort_v[0] = 1'b0;
    @(negedge clk);
    check("done_abort_valid", {63'd0, ov_o[0]}, 64'd0);

    // Asynchronous reset in the middle of RUN.
    send(0, 32'hAA, 32'h33, 1'b0, 1'b0, nw);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_idle_reset(0);
    q0.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    send(0, 32'h01, 32'h01, 1'b0, 1'b0, nw);
    wait_valid(0, lat);

    // WIDTH=1 truth table.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      send(2, {31'd0, v[2]}, {31'd0, v[1]}, v[0], 1'b0, nw);
      wait_valid(2, lat);
      check("latency_w1", 64'(lat), 64'd1);
    end

    // Random 32-bit traffic with random backpressure.
    for (int i = 0; i < 1000; i++)
      send(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, nw);
    @(posedge clk); #1 out_ready_v[1] = 1'b1;
    seen = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && seen < 200) begin
      @(negedge clk);
      seen++;
    end
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
